// File: rtl/neuron_window_seq.sv
// Sequential neuron: signed multiply-accumulate of N_INPUTS channels plus bias,
// followed by a selectable step / window / ReLU activation, with a start/done handshake.
module neuron_window_seq #(
  parameter int N_INPUTS = 4,
  parameter int X_W      = 8,
  parameter int W_W      = 8,
  parameter int ACC_W    = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_INPUTS*X_W-1:0]   in_x,
  input  logic [N_INPUTS*W_W-1:0]   in_w,
  input  logic [ACC_W-1:0]          bias,
  input  logic [ACC_W-1:0]          lo_th,
  input  logic [ACC_W-1:0]          hi_th,
  input  logic [1:0]                mode,
  output logic                      busy,
  output logic                      done,
  output logic                      fire,
  output logic [ACC_W-1:0]          y
);

  localparam int IDX_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int MIN_ACC_W = X_W + W_W + $clog2(N_INPUTS + 1) + 1;

  generate
    if (N_INPUTS < 1) begin : g_n_check
      $error("neuron_window_seq: N_INPUTS must be >= 1");
    end
    if (ACC_W < MIN_ACC_W) begin : g_acc_w_check
      $error("neuron_window_seq: ACC_W too narrow for X_W, W_W and N_INPUTS");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_ACT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic signed [X_W-1:0]   x_in [N_INPUTS];
  logic signed [W_W-1:0]   w_in [N_INPUTS];
  logic signed [X_W-1:0]   x_q  [N_INPUTS];
  logic signed [W_W-1:0]   w_q  [N_INPUTS];
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] lo_q;
  logic signed [ACC_W-1:0] hi_q;
  logic [1:0]              mode_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    done_q;
  logic                    fire_q;
  logic signed [ACC_W-1:0] y_q;

  logic                    accept;
  logic                    last_mac;
  logic signed [X_W-1:0]   x_sel;
  logic signed [W_W-1:0]   w_sel;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] prod;
  logic                    fire_d;
  logic signed [ACC_W-1:0] y_d;

  for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_unpack
    assign x_in[gi] = $signed(in_x[gi*X_W +: X_W]);
    assign w_in[gi] = $signed(in_w[gi*W_W +: W_W]);
  end

  // The ACT cycle only drains the finished sum, so it can also take a new
  // request; this keeps one result per N_INPUTS+1 clocks when start is held.
  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_ACT));
  assign last_mac = (idx_q == IDX_W'(N_INPUTS - 1));

  assign x_sel = x_q[idx_q];
  assign w_sel = w_q[idx_q];
  assign x_ext = {{(ACC_W-X_W){x_sel[X_W-1]}}, x_sel};
  assign w_ext = {{(ACC_W-W_W){w_sel[W_W-1]}}, w_sel};
  assign prod  = x_ext * w_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_MAC : S_IDLE;
      S_MAC:   state_d = last_mac ? S_ACT : S_MAC;
      S_ACT:   state_d = start ? S_MAC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    fire_d = 1'b0;
    y_d    = acc_q;
    case (mode_q)
      2'd1: fire_d = (acc_q >= lo_q) && (acc_q <= hi_q);
      2'd2: begin
        fire_d = (acc_q > 0);
        y_d    = (acc_q > 0) ? acc_q : '0;
      end
      default: fire_d = (acc_q >= lo_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
      acc_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      mode_q <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
      fire_q <= 1'b0;
      y_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_ACT) begin
        done_q <= 1'b1;
        fire_q <= fire_d;
        y_q    <= y_d;
      end
      if (accept) begin
        for (int i = 0; i < N_INPUTS; i++) begin
          x_q[i] <= x_in[i];
          w_q[i] <= w_in[i];
        end
        acc_q  <= $signed(bias);
        lo_q   <= $signed(lo_th);
        hi_q   <= $signed(hi_th);
        mode_q <= mode;
        idx_q  <= '0;
      end else if (state_q == S_MAC) begin
        acc_q <= acc_q + prod;
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign done = done_q;
  assign fire = fire_q;
  assign y    = y_q;

endmodule
